// File: rtl/sub_packetresp.sv
// Reply-packet buffer: ping-pong RAM of 32-bit reply words, drained in commit
// order as a zero-padded big-endian byte stream with a valid/ready handshake.
module sub_packetresp #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MIN_BYTES = 60
) (
  input  logic              ipb_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_commit,
  input  logic [ADDR_W:0]   wr_len,
  output logic              wr_busy,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  output logic              tx_done,
  output logic              err_overflow
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 3;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, PAD, FIN} state_t;

  logic [31:0]       r_mem [2*DEPTH];
  logic [31:0]       r_rd_q;
  logic [1:0]        r_full;
  logic              r_fill;
  logic              r_rd;
  logic              r_busy;
  logic              r_err;
  logic [LEN_W-1:0]  r_len [2];

  state_t            r_state;
  logic [ADDR_W-1:0] r_raddr;
  logic [31:0]       r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_dbytes;
  logic [CNT_W-1:0]  r_total;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_tx_last;
  logic              r_tx_done;

  logic              w_len_ok;
  logic              w_commit_ok;
  logic              w_release;
  logic [1:0]        w_full_nxt;
  logic              w_fill_nxt;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_dbytes;
  logic [CNT_W-1:0]  w_total;

  // Half ownership: a commit and a release can land together on different halves.
  always_comb begin
    w_len_ok    = (wr_len != '0) && (wr_len <= LEN_W'(DEPTH));
    w_commit_ok = wr_commit && !r_busy && w_len_ok;
    w_release   = (r_state == FIN);
    w_full_nxt  = r_full;
    w_fill_nxt  = r_fill;
    if (w_release) w_full_nxt[r_rd] = 1'b0;
    if (w_commit_ok) begin
      w_full_nxt[r_fill] = 1'b1;
      w_fill_nxt         = ~r_fill;
    end
  end

  always_comb begin
    w_xfer    = r_tx_valid && tx_ready;
    w_cnt_nxt = r_cnt + CNT_W'(1);
    w_dbytes  = {r_len[r_rd], 2'b00};
    w_total   = (w_dbytes > CNT_W'(MIN_BYTES)) ? w_dbytes : CNT_W'(MIN_BYTES);
  end

  always_ff @(posedge ipb_clk) begin
    if (reset) begin
      r_full   <= '0;
      r_fill   <= 1'b0;
      r_rd     <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      r_full <= w_full_nxt;
      r_fill <= w_fill_nxt;
      r_busy <= w_full_nxt[w_fill_nxt];
      if (w_release)               r_rd          <= ~r_rd;
      if (w_commit_ok)             r_len[r_fill] <= wr_len;
      if (wr_commit && !w_commit_ok) r_err       <= 1'b1;
    end
  end

  // Write port into the fill half; registered read port tracks the next word.
  always_ff @(posedge ipb_clk) begin
    if (wr_en && !r_busy) r_mem[{r_fill, wr_addr}] <= wr_data;
    r_rd_q <= r_mem[{r_rd, r_raddr}];
  end

  // r_rd_q always holds the word after the one being shifted out in r_sh.
  always_ff @(posedge ipb_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_raddr    <= '0;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_dbytes   <= '0;
      r_total    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_last  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_full[r_rd]) begin
            r_state <= LOAD;
            r_raddr <= ADDR_W'(1);
          end
        end
        LOAD: begin
          r_sh       <= {r_rd_q[23:0], 8'h00};
          r_tx_data  <= r_rd_q[31:24];
          r_tx_valid <= 1'b1;
          r_tx_last  <= 1'b0;
          r_cnt      <= '0;
          r_dbytes   <= w_dbytes;
          r_total    <= w_total;
          r_state    <= SEND;
        end
        SEND, PAD: begin
          if (w_xfer) begin
            r_cnt     <= w_cnt_nxt;
            r_tx_last <= (w_cnt_nxt == r_total - CNT_W'(1));
            if (w_cnt_nxt == r_total) begin
              r_state    <= FIN;
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_tx_data  <= '0;
              r_tx_done  <= 1'b1;
            end else if (r_state == PAD) begin
              r_tx_data <= '0;
            end else if (w_cnt_nxt == r_dbytes) begin
              r_state   <= PAD;
              r_tx_data <= '0;
            end else if (w_cnt_nxt[1:0] == 2'b00) begin
              r_tx_data <= r_rd_q[31:24];
              r_sh      <= {r_rd_q[23:0], 8'h00};
              r_raddr   <= r_raddr + ADDR_W'(1);
            end else begin
              r_tx_data <= r_sh[31:24];
              r_sh      <= {r_sh[23:0], 8'h00};
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_raddr <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_busy      = r_busy;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign tx_last      = r_tx_last;
  assign tx_done      = r_tx_done;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_sub_packetresp.sv
// Bench for sub_packetresp: random traffic against a packet-level model that
// turns each accepted commit into its expected padded byte sequence.
module tb_sub_packetresp;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned MIN_BYTES = 60;
  localparam int unsigned DEPTH     = 2**ADDR_W;

  logic              ipb_clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_commit;
  logic [ADDR_W:0]   wr_len;
  logic              wr_busy;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_last;
  logic              tx_done;
  logic              err_overflow;

  sub_packetresp #(.ADDR_W(ADDR_W), .MIN_BYTES(MIN_BYTES)) dut (
    .ipb_clk(ipb_clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_len(wr_len), .wr_busy(wr_busy),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_done(tx_done), .err_overflow(err_overflow)
  );

  always #5 ipb_clk = ~ipb_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending packets, expected bytes {last, data}, sticky error.
  logic [31:0] shadow [2][DEPTH];
  logic [8:0]  exp_q [$];
  int          outs = 0;
  bit          fill_m = 1'b0;
  bit          err_m = 1'b0;
  int          lat_cd = 0;
  bit          in_pkt = 1'b0;
  bit          done_exp = 1'b0;
  bit          post_rst = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;
  int unsigned xfer_cnt = 0;
  int          rdy_mode = 2;

  task automatic push_pkt(input int len);
    int n;
    logic [31:0] w;
    n = (4 * len > int'(MIN_BYTES)) ? 4 * len : int'(MIN_BYTES);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      if (i < 4 * len) begin
        w = shadow[fill_m][i / 4];
        b = w[31 - 8 * (i % 4) -: 8];
      end else begin
        b = 8'h00;
      end
      exp_q.push_back({(i == n - 1), b});
    end
  endtask

  // Monitor and model update, sampled on the falling edge.
  initial begin
    logic [8:0] e;
    bit busy_m;
    bit acc;
    forever begin
      @(negedge ipb_clk);
      if (post_rst) begin
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'd0);
        check_eq("rst_last", 32'(tx_last), 32'd0);
        post_rst = 1'b0;
      end
      if (reset) begin
        exp_q.delete();
        outs = 0; fill_m = 1'b0; err_m = 1'b0; lat_cd = 0;
        in_pkt = 1'b0; done_exp = 1'b0; prev_stall = 1'b0; post_rst = 1'b1;
      end else begin
        busy_m = (outs == 2);
        check_eq("busy", 32'(wr_busy), 32'(busy_m));
        check_eq("err", 32'(err_overflow), 32'(err_m));
        check_eq("done", 32'(tx_done), 32'(done_exp));
        if (outs == 0) check_eq("idle_valid", 32'(tx_valid), 32'd0);
        if (lat_cd > 0) begin
          lat_cd--;
          check_eq("start_latency", 32'(tx_valid), 32'(lat_cd == 0));
        end
        if (in_pkt) check_eq("gap", 32'(tx_valid), 32'd1);
        if (prev_stall) begin
          check_eq("hold_data", 32'(tx_data), 32'(prev_data));
          check_eq("hold_last", 32'(tx_last), 32'(prev_last));
        end
        done_exp = 1'b0;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("byte", 32'(tx_data), 32'(e[7:0]));
            check_eq("last", 32'(tx_last), 32'(e[8]));
            in_pkt   = !e[8];
            done_exp = e[8];
          end
          xfer_cnt++;
        end else if (tx_valid) begin
          in_pkt = 1'b1;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;

        if (wr_en && !busy_m) shadow[fill_m][wr_addr] = wr_data;
        acc = 1'b0;
        if (wr_commit) begin
          if (busy_m || wr_len == 0 || int'(wr_len) > int'(DEPTH)) begin
            err_m = 1'b1;
          end else begin
            push_pkt(int'(wr_len));
            if (outs == 0) lat_cd = 3;
            fill_m = ~fill_m;
            acc = 1'b1;
          end
        end
        outs = outs + int'(acc) - int'(tx_done);
      end
    end
  end

  // Sink: always ready, random back-pressure, or fully stalled.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge ipb_clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge ipb_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit(input logic [ADDR_W:0] len);
    wr_commit = 1'b1;
    wr_len    = len;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget && wr_busy; i++) tick();
    check_eq("busy_timeout", 32'(wr_busy), 32'd0);
  endtask

  task automatic send_pkt(input int len);
    wait_not_busy(5000);
    for (int a = 0; a < len; a++) write_word(a, $urandom);
    commit((ADDR_W+1)'(len));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || outs != 0); i++) tick();
    check_eq("drain_bytes_left", 32'(exp_q.size()), 32'd0);
    check_eq("drain_pkts_left", 32'(outs), 32'd0);
  endtask

  initial begin
    int unsigned base;
    int lens [8] = '{1, 14, 15, 16, 17, 2, 40, 33};
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_commit = 1'b0; wr_len = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("reset_valid", 32'(tx_valid), 32'd0);
    check_eq("reset_busy", 32'(wr_busy), 32'd0);
    check_eq("reset_done", 32'(tx_done), 32'd0);
    check_eq("reset_err", 32'(err_overflow), 32'd0);
    check_eq("reset_data", 32'(tx_data), 32'd0);
    check_eq("reset_last", 32'(tx_last), 32'd0);

    // Two-word packet, padded to the minimum, sink always ready.
    rdy_mode = 0;
    base = xfer_cnt;
    write_word(0, 32'h01020304);
    write_word(1, 32'h05060708);
    commit(10'd2);
    check_eq("short_busy", 32'(wr_busy), 32'd0);
    drain(500);
    check_eq("short_count", xfer_cnt - base, 32'(MIN_BYTES));

    // Fill both halves while stalled; third commit and a write must be rejected.
    rdy_mode = 2;
    tick();
    send_pkt(3);
    send_pkt(20);
    check_eq("bb_busy", 32'(wr_busy), 32'd1);
    write_word(0, 32'hDEADBEEF);
    commit(10'd5);
    check_eq("bb_err", 32'(err_overflow), 32'd1);
    repeat (10) tick();
    rdy_mode = 0;
    drain(1000);

    // 128-word packet under random back-pressure.
    do_reset();
    rdy_mode = 1;
    base = xfer_cnt;
    send_pkt(128);
    drain(4000);
    check_eq("rand128_count", xfer_cnt - base, 32'd512);

    // Zero and oversized lengths are errors; a full-size half emits 2048 bytes.
    do_reset();
    rdy_mode = 0;
    base = xfer_cnt;
    commit(10'd0);
    check_eq("len0_err", 32'(err_overflow), 32'd1);
    commit(10'd513);
    repeat (20) tick();
    check_eq("badlen_count", xfer_cnt - base, 32'd0);
    do_reset();
    base = xfer_cnt;
    send_pkt(512);
    drain(5000);
    check_eq("len512_count", xfer_cnt - base, 32'd2048);

    // Reset while byte 5 is on the bus, then a fresh packet.
    do_reset();
    rdy_mode = 0;
    base = xfer_cnt;
    send_pkt(10);
    for (int i = 0; i < 200 && (xfer_cnt - base) < 4; i++) tick();
    check_eq("rst_at_byte5", xfer_cnt - base, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_valid", 32'(tx_valid), 32'd0);
    check_eq("midrst_busy", 32'(wr_busy), 32'd0);
    tick();
    base = xfer_cnt;
    send_pkt(16);
    drain(500);
    check_eq("after_rst_count", xfer_cnt - base, 32'd64);

    // Mixed lengths around the padding threshold with random back-pressure.
    rdy_mode = 1;
    for (int k = 0; k < 14; k++) begin
      send_pkt((k < 8) ? lens[k] : int'($urandom_range(1, 40)));
      if (wr_busy && $urandom_range(0, 2) == 0) commit(10'd4);
    end
    drain(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
